// File: rtl/ws2812b_frame_sequencer.sv
// Frame sequencer for the ws2812b serializer: host pixel buffer, one-frame-per-start streaming, auto-refresh.
// Optional WS2812B_SEQ_BRIGHTNESS_EN adds the BRIGHT register (0x5) and per-channel scaling at FETCH.
module ws2812b_frame_sequencer #(
    parameter int NUM_LEDS       = 16,
    parameter int REFRESH_CYCLES = 1066666
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  address,
    input  logic        data_write,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [23:0] ledstrip_data,
    output logic        ledstrip_valid,
    output logic        ledstrip_latch,
    input  logic        ledstrip_ready
);

    localparam int               PIX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(NUM_LEDS - 1);
    localparam logic [7:0]       NUM_LEDS_B = 8'(NUM_LEDS);
    localparam logic [20:0]      RELOAD     = 21'(REFRESH_CYCLES - 1);

    // Handshake: a pixel is offered only in SEND while ledstrip_ready=1 (valid for one cycle);
    // the serializer must then drop ready (busy) and raise it again before the next pixel.
    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_BUSY, WAIT_READY} state_t;
    state_t state, state_next;

    logic [7:0]       idx, g_reg, r_reg, b_reg;
    logic             auto_en, pending;
    logic [20:0]      timer;
    logic [PIX_W-1:0] pix;
    logic [23:0]      pix_buf [NUM_LEDS];
    logic [23:0]      fetch_pix;

    logic wr_ctrl, wr_b, start_wr, expire, start_evt, busy, last;

    assign wr_ctrl   = data_write && (address == 4'h0);
    assign wr_b      = data_write && (address == 4'h4);
    assign start_wr  = wr_ctrl && data_in[0];
    assign expire    = auto_en && (timer == 21'd0);
    assign start_evt = start_wr || pending || expire;
    assign busy      = (state != IDLE);
    assign last      = (pix == LAST_PIX);

`ifdef WS2812B_SEQ_BRIGHTNESS_EN
    logic [7:0] bright;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] k);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, k} + 16'd1);
        return p[15:8];
    endfunction

    always_comb begin
        fetch_pix = {scale(pix_buf[pix][23:16], bright),
                     scale(pix_buf[pix][15:8],  bright),
                     scale(pix_buf[pix][7:0],   bright)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            bright <= 8'hFF;
        else if (data_write && (address == 4'h5))
            bright <= data_in;
    end
`else
    always_comb begin
        fetch_pix = pix_buf[pix];
    end
`endif

    always_comb begin
        state_next     = state;
        ledstrip_valid = 1'b0;
        ledstrip_latch = 1'b0;
        case (state)
            IDLE:       if (start_evt) state_next = FETCH;
            FETCH:      state_next = SEND;
            SEND: begin
                if (ledstrip_ready) begin
                    ledstrip_valid = 1'b1;
                    ledstrip_latch = last;
                    state_next     = WAIT_BUSY;
                end
            end
            WAIT_BUSY:  if (!ledstrip_ready) state_next = WAIT_READY;
            WAIT_READY: if (ledstrip_ready) state_next = last ? IDLE : FETCH;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pix <= '0;
        else if ((state == IDLE) && start_evt)
            pix <= '0;
        else if ((state == WAIT_READY) && ledstrip_ready && !last)
            pix <= pix + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ledstrip_data <= 24'd0;
        else if (state == FETCH)
            ledstrip_data <= fetch_pix;
    end

    // A start or expiry that cannot be served now is remembered once; IDLE always consumes it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= 1'b0;
        else if (state == IDLE) begin
            if (start_evt) pending <= 1'b0;
        end else if (start_wr || expire)
            pending <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_en <= 1'b0;
            timer   <= RELOAD;
        end else begin
            if (wr_ctrl) auto_en <= data_in[1];
            if ((wr_ctrl && data_in[1] && !auto_en) || expire)
                timer <= RELOAD;
            else if (auto_en)
                timer <= timer - 21'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= 8'd0;
            g_reg <= 8'd0;
            r_reg <= 8'd0;
            b_reg <= 8'd0;
            for (int i = 0; i < NUM_LEDS; i++) pix_buf[i] <= 24'd0;
        end else if (data_write) begin
            case (address)
                4'h1: idx   <= data_in;
                4'h2: g_reg <= data_in;
                4'h3: r_reg <= data_in;
                4'h4: begin
                    b_reg <= data_in;
                    if (idx < NUM_LEDS_B)
                        pix_buf[idx[PIX_W-1:0]] <= {g_reg, r_reg, data_in};
                    idx <= (idx >= NUM_LEDS_B - 8'd1) ? 8'd0 : idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_out = 8'd0;
        case (address)
            4'h0: data_out = {5'b0, pending, auto_en, busy};
            4'h1: data_out = idx;
            4'h2: data_out = g_reg;
            4'h3: data_out = r_reg;
            4'h4: data_out = b_reg;
`ifdef WS2812B_SEQ_BRIGHTNESS_EN
            4'h5: data_out = bright;
`endif
            default: data_out = 8'd0;
        endcase
    end

    logic unused_wr_b;
    assign unused_wr_b = wr_b;

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Directed bench for ws2812b_frame_sequencer (NUM_LEDS=4, REFRESH_CYCLES=100) with a serializer ready model.
module tb_ws2812b_frame_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  address;
    logic        data_write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [23:0] ledstrip_data;
    logic        ledstrip_valid;
    logic        ledstrip_latch;
    logic        ledstrip_ready;

    ws2812b_frame_sequencer #(.NUM_LEDS(N), .REFRESH_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_write(data_write),
        .data_in(data_in), .data_out(data_out), .ledstrip_data(ledstrip_data),
        .ledstrip_valid(ledstrip_valid), .ledstrip_latch(ledstrip_latch),
        .ledstrip_ready(ledstrip_ready)
    );

    always #5 clk = ~clk;

    // Serializer model: ready drops for 10 cycles after each accepted pixel; ready_en forces it low.
    logic ready_en;
    int   rdy_cnt;
    assign ledstrip_ready = ready_en && (rdy_cnt == 0);

    always @(posedge clk) begin
        if (!rst_n)              rdy_cnt <= 0;
        else if (ledstrip_valid) rdy_cnt <= 10;
        else if (rdy_cnt > 0)    rdy_cnt <= rdy_cnt - 1;
    end

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int          tests = 0;
    int          fails = 0;
    int          valid_cnt = 0;
    int          latch_cnt = 0;
    int          prot_err = 0;
    int          pix_in_frame = 0;
    logic        prev_valid = 1'b0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_pix;
    int unsigned starts[$];

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid   = 1'b0;
            pix_in_frame = 0;
        end else begin
            if (ledstrip_valid) begin
                valid_cnt++;
                if (!ledstrip_ready || prev_valid) prot_err++;
                if (ledstrip_latch !== (pix_in_frame == N - 1)) prot_err++;
                if (ledstrip_latch) latch_cnt++;
                if (pix_in_frame == 0) starts.push_back(cycle);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL pixel_unexpected got=%06h", ledstrip_data);
                end else begin
                    exp_pix = exp_q.pop_front();
                    if (ledstrip_data !== exp_pix) begin
                        fails++;
                        $display("FAIL pixel_data got=%06h exp=%06h", ledstrip_data, exp_pix);
                    end
                end
                pix_in_frame = (pix_in_frame == N - 1) ? 0 : pix_in_frame + 1;
            end
            prev_valid = ledstrip_valid;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk); #1;
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
        @(posedge clk); #1;
    endtask

    task automatic wr_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        wr(4'h2, g);
        wr(4'h3, r);
        wr(4'h4, b);
    endtask

    task automatic wait_idle(output bit to);
        if (address != 4'h0) begin
            address = 4'h0;
            @(posedge clk); #1;
        end
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (data_out[0] == 1'b0) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_latch(input int n, output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (latch_cnt >= n) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        tests++; if (ledstrip_valid !== 1'b0 || ledstrip_latch !== 1'b0) begin
            fails++; $display("FAIL reset_valid_latch got=%b%b exp=00", ledstrip_valid, ledstrip_latch); end
        tests++; if (ledstrip_data !== 24'd0) begin
            fails++; $display("FAIL reset_data got=%06h exp=000000", ledstrip_data); end
        rd(4'h0, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_ctrl got=%02h exp=00", d); end
        for (int a = 1; a <= 4; a++) begin
            rd(4'(a), d);
            tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_reg%0d got=%02h exp=00", a, d); end
        end
        rd(4'h5, d);
`ifdef WS2812B_SEQ_BRIGHTNESS_EN
        tests++; if (d !== 8'hFF) begin fails++; $display("FAIL reset_bright got=%02h exp=ff", d); end
`else
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_bright got=%02h exp=00", d); end
`endif
    endtask

    task automatic test_frame;
        logic [7:0] d;
        bit to;
        int v0, l0;
        wr(4'h1, 8'h00);
        for (int i = 0; i < N; i++) wr_pixel(8'h11, 8'h22, 8'h33);
        rd(4'h1, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL index_wrap got=%02h exp=00", d); end
        rd(4'h4, d);
        tests++; if (d !== 8'h33) begin fails++; $display("FAIL b_readback got=%02h exp=33", d); end
        v0 = valid_cnt; l0 = latch_cnt;
        for (int i = 0; i < N; i++) exp_q.push_back(24'h112233);
        wr(4'h0, 8'h01);
        wait_idle(to);
        tests++; if (to !== 1'b0) begin fails++; $display("FAIL frame_timeout got=1 exp=0"); end
        tests++; if (valid_cnt - v0 !== N) begin fails++; $display("FAIL frame_valid_count got=%0d exp=%0d", valid_cnt - v0, N); end
        tests++; if (latch_cnt - l0 !== 1) begin fails++; $display("FAIL frame_latch_count got=%0d exp=1", latch_cnt - l0); end
        tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL frame_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_latency;
        bit to;
        int seen;
        for (int i = 0; i < N; i++) exp_q.push_back(24'h112233);
        wr(4'h0, 8'h01);
        tests++; if (ledstrip_valid !== 1'b0 || data_out[0] !== 1'b1) begin
            fails++; $display("FAIL lat_fetch got=valid%b busy%b exp=valid0 busy1", ledstrip_valid, data_out[0]); end
        @(posedge clk); #1;
        tests++; if (ledstrip_valid !== 1'b1 || ledstrip_latch !== 1'b0) begin
            fails++; $display("FAIL lat_send got=valid%b latch%b exp=valid1 latch0", ledstrip_valid, ledstrip_latch); end
        wait_idle(to);
        tests++; if (to !== 1'b0) begin fails++; $display("FAIL lat_timeout got=1 exp=0"); end
        ready_en = 1'b0;
        for (int i = 0; i < N; i++) exp_q.push_back(24'h112233);
        wr(4'h0, 8'h01);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ledstrip_valid) seen++;
        end
        tests++; if (seen !== 0 || data_out[0] !== 1'b1) begin
            fails++; $display("FAIL stall_send got=valids%0d busy%b exp=valids0 busy1", seen, data_out[0]); end
        ready_en = 1'b1;
        #1;
        tests++; if (ledstrip_valid !== 1'b1) begin fails++; $display("FAIL stall_release got=%b exp=1", ledstrip_valid); end
        @(posedge clk); #1;
        wait_idle(to);
        tests++; if (to !== 1'b0 || exp_q.size() !== 0) begin
            fails++; $display("FAIL stall_frame got=to%0d left%0d exp=to0 left0", to, exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        bit to, found;
        int l0;
        l0 = latch_cnt;
        for (int i = 0; i < 2 * N; i++) exp_q.push_back(24'h112233);
        wr(4'h0, 8'h01);
        repeat (15) @(posedge clk);
        #1;
        wr(4'h0, 8'h01);
        rd(4'h0, d);
        tests++; if (d !== 8'h05) begin fails++; $display("FAIL pending_set got=%02h exp=05", d); end
        wr(4'h0, 8'h01);
        rd(4'h0, d);
        tests++; if (d !== 8'h05) begin fails++; $display("FAIL pending_absorb got=%02h exp=05", d); end
        wait_latch(l0 + 1, to);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (data_out[0] == 1'b0) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        tests++; if (found !== 1'b1 || data_out[0] !== 1'b1) begin
            fails++; $display("FAIL pending_restart got=idle%b busy%b exp=idle1 busy1", found, data_out[0]); end
        wait_latch(l0 + 2, to);
        wait_idle(to);
        repeat (60) @(posedge clk);
        #1;
        tests++; if (latch_cnt - l0 !== 2 || exp_q.size() !== 0) begin
            fails++; $display("FAIL pending_frames got=%0d left%0d exp=2 left0", latch_cnt - l0, exp_q.size()); end
        rd(4'h0, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL pending_clear got=%02h exp=00", d); end
    endtask

    task automatic test_auto_refresh;
        logic [7:0] d;
        bit to;
        int unsigned t0;
        int l0;
        starts.delete();
        for (int i = 0; i < 3 * N; i++) exp_q.push_back(24'h112233);
        wr(4'h0, 8'h02);
        t0 = cycle;
        for (int i = 0; i < 500; i++) begin
            if (starts.size() >= 3) break;
            @(posedge clk); #1;
        end
        wait_idle(to);
        tests++; if (starts.size() < 3) begin fails++; $display("FAIL auto_frames got=%0d exp=3", starts.size()); end
        else begin
            tests++; if (starts[0] - t0 !== 101) begin fails++; $display("FAIL auto_first got=%0d exp=101", starts[0] - t0); end
            tests++; if (starts[1] - starts[0] !== 100 || starts[2] - starts[1] !== 100) begin
                fails++; $display("FAIL auto_period got=%0d,%0d exp=100,100", starts[1] - starts[0], starts[2] - starts[1]); end
        end
        ready_en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (data_out[0] == 1'b1) break;
            @(posedge clk); #1;
        end
        repeat (110) @(posedge clk);
        #1;
        rd(4'h0, d);
        tests++; if (d !== 8'h07) begin fails++; $display("FAIL auto_pending got=%02h exp=07", d); end
        wr(4'h0, 8'h00);
        rd(4'h0, d);
        tests++; if (d !== 8'h05) begin fails++; $display("FAIL auto_disable got=%02h exp=05", d); end
        l0 = latch_cnt;
        for (int i = 0; i < 2 * N; i++) exp_q.push_back(24'h112233);
        ready_en = 1'b1;
        wait_latch(l0 + 2, to);
        wait_idle(to);
        repeat (250) @(posedge clk);
        #1;
        tests++; if (latch_cnt - l0 !== 2 || exp_q.size() !== 0) begin
            fails++; $display("FAIL auto_drain got=%0d left%0d exp=2 left0", latch_cnt - l0, exp_q.size()); end
    endtask

    task automatic test_index_boundary;
        logic [7:0] d;
        bit to;
        wr(4'h1, 8'h01);
        wr_pixel(8'h01, 8'h02, 8'h03);
        rd(4'h1, d);
        tests++; if (d !== 8'h02) begin fails++; $display("FAIL index_inc got=%02h exp=02", d); end
        wr_pixel(8'h04, 8'h05, 8'h06);
        wr(4'h1, 8'(N));
        rd(4'h1, d);
        tests++; if (d !== 8'(N)) begin fails++; $display("FAIL index_oob_store got=%02h exp=%02h", d, 8'(N)); end
        wr_pixel(8'hAA, 8'hBB, 8'hCC);
        rd(4'h1, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL index_oob_wrap got=%02h exp=00", d); end
        wr(4'h1, 8'h09);
        wr(4'h4, 8'hDD);
        rd(4'h1, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL index_far_wrap got=%02h exp=00", d); end
        rd(4'h7, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL unmapped_read got=%02h exp=00", d); end
        exp_q.push_back(24'h112233);
        exp_q.push_back(24'h010203);
        exp_q.push_back(24'h040506);
        exp_q.push_back(24'h112233);
        wr(4'h0, 8'h01);
        wait_idle(to);
        tests++; if (to !== 1'b0 || exp_q.size() !== 0) begin
            fails++; $display("FAIL index_frame got=to%0d left%0d exp=to0 left0", to, exp_q.size()); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        bit to;
        int v0;
        wr(4'h1, 8'h02);
        v0 = valid_cnt;
        for (int i = 0; i < N; i++) exp_q.push_back(24'h112233);
        exp_q[1] = 24'h010203;
        exp_q[2] = 24'h040506;
        wr(4'h0, 8'h01);
        for (int i = 0; i < 200; i++) begin
            if (valid_cnt - v0 >= 2) break;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (ledstrip_valid !== 1'b0 || ledstrip_latch !== 1'b0 || ledstrip_data !== 24'd0) begin
            fails++; $display("FAIL rst_mid_outputs got=v%b l%b d%06h exp=v0 l0 d000000", ledstrip_valid, ledstrip_latch, ledstrip_data); end
        rst_n = 1'b1;
        exp_q.delete();
        rd(4'h0, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL rst_mid_ctrl got=%02h exp=00", d); end
        rd(4'h1, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL rst_mid_index got=%02h exp=00", d); end
        for (int i = 0; i < N; i++) exp_q.push_back(24'h000000);
        wr(4'h0, 8'h01);
        wait_idle(to);
        tests++; if (to !== 1'b0 || exp_q.size() !== 0) begin
            fails++; $display("FAIL rst_mid_cleared got=to%0d left%0d exp=to0 left0", to, exp_q.size()); end
    endtask

    task automatic test_brightness;
        logic [7:0] d;
        bit to;
        wr(4'h5, 8'h7F);
        rd(4'h5, d);
`ifdef WS2812B_SEQ_BRIGHTNESS_EN
        tests++; if (d !== 8'h7F) begin fails++; $display("FAIL bright_read got=%02h exp=7f", d); end
        exp_q.push_back(24'h7F4000);
`else
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL bright_read got=%02h exp=00", d); end
        exp_q.push_back(24'hFF8001);
`endif
        for (int i = 1; i < N; i++) exp_q.push_back(24'h000000);
        wr(4'h1, 8'h00);
        wr_pixel(8'hFF, 8'h80, 8'h01);
        wr(4'h0, 8'h01);
        wait_idle(to);
        tests++; if (to !== 1'b0 || exp_q.size() !== 0) begin
            fails++; $display("FAIL bright_frame got=to%0d left%0d exp=to0 left0", to, exp_q.size()); end
    endtask

    initial begin
        rst_n      = 1'b0;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;
        ready_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_frame();
        test_latency();
        test_back_to_back();
        test_auto_refresh();
        test_index_boundary();
        test_reset_midframe();
        test_brightness();

        tests++; if (prot_err !== 0) begin fails++; $display("FAIL handshake_protocol got=%0d exp=0", prot_err); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ws2812b_frame_sequencer.md
# ws2812b_frame_sequencer

Frame-level controller for the `ws2812b` serializer. It holds a host-writable pixel buffer of `NUM_LEDS` GRB words and streams one full frame per start event through the serializer's `valid`/`latch`/`ready` handshake, asserting `latch` on the last pixel. It can also re-send the frame autonomously on a programmable refresh period. It sits between the TinyQV byte-peripheral register interface and a single `ws2812b` instance.

## Interface
Parameters:
- `NUM_LEDS`, 16: pixels per frame, 1..64.
- `REFRESH_CYCLES`, 1066666: auto-refresh period in `clk` cycles (60 Hz at 64 MHz).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `address` in 4: register select.
- `data_write` in 1: host write strobe, one cycle.
- `data_in` in 8: host write data.
- `data_out` out 8: host read data, combinational on `address`.
- `ledstrip_data` out 24: GRB pixel to the serializer, registered.
- `ledstrip_valid` out 1: one-cycle pixel strobe.
- `ledstrip_latch` out 1: high together with `valid` on the last pixel of a frame.
- `ledstrip_ready` in 1: serializer idle and able to accept a pixel.

## Operation
Registers:
- 0x0 CTRL:
  - Write: bit0 = start (self-clearing), bit1 = `auto_en`.
  - Read: `{5'b0, pending, auto_en, busy}`.
- 0x1 INDEX: write pointer, read back as written. Values ≥ `NUM_LEDS` are stored, but pixel commits at that index are dropped.
- 0x2 G, 0x3 R, 0x4 B: staging bytes, readable.
- Writing B commits `{G,R,B}` to `buf[INDEX]` in the same cycle, then increments INDEX.
  - The increment from `NUM_LEDS-1` wraps to 0.
  - The increment from ≥ `NUM_LEDS` also wraps to 0.
- 0x5 BRIGHT: see Configuration. Reads 0 when the feature is absent.
- Other addresses: writes are ignored; reads return 0.

FSM states: IDLE, FETCH, SEND, WAIT_BUSY, WAIT_READY.
- IDLE:
  - Exits on a start event: CTRL start write, `pending`, or refresh-timer expiry with `auto_en`=1.
  - On exit: `pix` ← 0, `pending` ← 0, next state FETCH.
- FETCH: `ledstrip_data` ← `buf[pix]` (scaled if enabled); next state SEND.
- SEND:
  - If `ledstrip_ready`=1: drive `valid`=1 for exactly one cycle, with `latch` = (`pix`==`NUM_LEDS-1`); next state WAIT_BUSY.
  - Otherwise hold in SEND.
- WAIT_BUSY: stay until `ledstrip_ready`=0; then WAIT_READY.
- WAIT_READY: stay until `ledstrip_ready`=1.
  - If `pix`==`NUM_LEDS-1`: go to IDLE.
  - Otherwise: `pix`++ and go to FETCH.
- `busy` = state≠IDLE.

Refresh timer:
- 21-bit down-counter, reloaded with `REFRESH_CYCLES-1` on reset, on expiry, and on writing `auto_en` 0→1.
- Counts only while `auto_en`=1.
- Expiry while busy sets `pending`.

Boundary rules:
- Start write while busy: sets `pending`. Only one frame is queued; further starts are absorbed.
- Pixel writes during a frame are allowed. A pixel is sampled at its FETCH cycle, so writes to indices > `pix` appear in the current frame.
- Clearing `auto_en` does not cancel a frame in flight or a queued `pending`.
- Reset mid-frame: all state returns to reset values immediately. No latch is issued; the serializer is reset by the same `rst_n`.

## Timing
Reset values:
- `ledstrip_valid`=0, `ledstrip_latch`=0, `ledstrip_data`=0.
- `buf` all 0; G/R/B/INDEX = 0; `auto_en`=0, `pending`=0; BRIGHT = 0xFF; state IDLE.

Latency:
- A start write in cycle T puts the FSM in FETCH at T+1 and SEND at T+2.
- With `ready`=1, `valid` is high in T+2.
- `ledstrip_data` is stable from the FETCH edge through the following WAIT_READY.

Handshake:
- `valid` is never asserted while `ready`=0.
- `valid` is never high in two consecutive cycles.
- Exactly `NUM_LEDS` `valid` pulses and exactly one `latch` are produced per frame.
- Between pixels, `ready` must be seen low, then high. A serializer that never drops `ready` stalls the FSM in WAIT_BUSY; this is by design.

## Configuration
`WS2812B_SEQ_BRIGHTNESS_EN`:
- Defined: BRIGHT register (0x5) exists. At FETCH, each channel `c` becomes `(c*(BRIGHT+1))>>8`, computed at 16 bits and truncated to 8. BRIGHT=0xFF is identity; BRIGHT=0x00 maps 0xFF to 0x00.
- Undefined: register absent (reads 0, writes ignored); `ledstrip_data` = `buf[pix]` unmodified.

## Test plan
- Write INDEX=0, then G,R,B = 0x11,0x22,0x33 four times, then CTRL=0x01; model `ready` (low 10 cycles after each `valid`) -> `data` 0x112233 on pixels 0..3, `latch` only with the 4th (`NUM_LEDS`=4 build), `busy` drops after the last `ready` rise.
- Start write at T with `ready`=1 -> `valid` at T+2; hold `ready`=0 -> FSM waits in SEND with `valid`=0.
- Start again mid-frame -> CTRL reads `pending`=1; a second frame begins the cycle after IDLE, and a third start is absorbed.
- `auto_en`=1 with `REFRESH_CYCLES`=100 -> frames start every 100 cycles while idle; expiry during a frame sets `pending`.
- INDEX=`NUM_LEDS`, write B -> buffer unchanged, INDEX reads 0; assert `rst_n`=0 mid-frame -> next cycle `valid`=`latch`=0, `busy`=0, buffer cleared.
- With macro defined: BRIGHT=0x7F, pixel 0xFF8001 -> `data` 0x7F4000; with macro undefined -> 0xFF8001, and address 0x5 reads 0.
